// File: rtl/regfile_readback_fsm.sv
// Read-only register-file scanner: walks A/B selects, captures the bus, shows each value on 4 hex digits.
// Optional running checksum of all captures, enabled with `define REGFILE_READBACK_CHECKSUM_EN.
module regfile_readback_fsm #(
    parameter int          NUM_REGS      = 16,
    parameter int          DWELL_CYCLES  = 25000000,
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [15:0] PASS_INST     = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        hold,
    input  logic [15:0] bus_in,
    output logic [15:0] regEnable,
    output logic [3:0]  ctrlA,
    output logic [3:0]  ctrlB,
    output logic [15:0] inst,
    output logic [15:0] data_out,
    output logic [3:0]  sel_idx,
    output logic        valid,
    output logic        busy,
    output logic        done,
    output logic [15:0] checksum,
    output logic [6:0]  out0,
    output logic [6:0]  out1,
    output logic [6:0]  out2,
    output logic [6:0]  out3
);

    localparam int          DW_EFF   = (DWELL_CYCLES < 1) ? 1 : DWELL_CYCLES;
    localparam int          ST_EFF   = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam logic [31:0] DW_LAST  = 32'(DW_EFF - 1);
    localparam logic [31:0] ST_LAST  = 32'(ST_EFF - 1);
    localparam logic [3:0]  LAST_IDX = 4'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        CAPTURE,
        DWELL,
        NEXT,
`ifdef REGFILE_READBACK_CHECKSUM_EN
        SUM,
`endif
        DONE
    } state_t;

    state_t      state;
    logic [31:0] cnt;

    // Active-low segments, bit order gfedcba (hexTo7Seg encoding).
    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign regEnable = 16'h0000;

`ifdef REGFILE_READBACK_CHECKSUM_EN
    logic [15:0] csum;
    assign checksum = csum;
`else
    assign checksum = 16'h0000;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            ctrlA    <= '0;
            ctrlB    <= '0;
            inst     <= '0;
            data_out <= '0;
            sel_idx  <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            out0     <= hex7(4'h0);
            out1     <= hex7(4'h0);
            out2     <= hex7(4'h0);
            out3     <= hex7(4'h0);
`ifdef REGFILE_READBACK_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= SELECT;
                        cnt   <= '0;
                        ctrlA <= '0;
                        ctrlB <= '0;
                        inst  <= PASS_INST;
                        busy  <= 1'b1;
                        done  <= 1'b0;
`ifdef REGFILE_READBACK_CHECKSUM_EN
                        csum  <= '0;
`endif
                    end
                end
                SELECT: begin
                    if (cnt == ST_LAST) begin
                        state <= CAPTURE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                CAPTURE: begin
                    data_out <= bus_in;
                    sel_idx  <= ctrlA;
                    valid    <= 1'b1;
                    out0     <= hex7(bus_in[3:0]);
                    out1     <= hex7(bus_in[7:4]);
                    out2     <= hex7(bus_in[11:8]);
                    out3     <= hex7(bus_in[15:12]);
`ifdef REGFILE_READBACK_CHECKSUM_EN
                    csum     <= csum + bus_in;
`endif
                    cnt      <= '0;
                    state    <= DWELL;
                end
                DWELL: begin
                    if (!hold) begin
                        if (cnt == DW_LAST) begin
                            state <= NEXT;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                end
                NEXT: begin
                    if (ctrlA == LAST_IDX) begin
`ifdef REGFILE_READBACK_CHECKSUM_EN
                        // Checksum is shown like one more register, tagged F.
                        state    <= SUM;
                        cnt      <= '0;
                        data_out <= csum;
                        sel_idx  <= 4'hF;
                        valid    <= 1'b1;
                        out0     <= hex7(csum[3:0]);
                        out1     <= hex7(csum[7:4]);
                        out2     <= hex7(csum[11:8]);
                        out3     <= hex7(csum[15:12]);
`else
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        inst  <= '0;
`endif
                    end else begin
                        ctrlA <= ctrlA + 4'd1;
                        ctrlB <= ctrlA + 4'd1;
                        cnt   <= '0;
                        state <= SELECT;
                    end
                end
`ifdef REGFILE_READBACK_CHECKSUM_EN
                SUM: begin
                    if (!hold) begin
                        if (cnt == DW_LAST) begin
                            state <= DONE;
                            cnt   <= '0;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            inst  <= '0;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    inst  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_readback_fsm.sv
// Bench for regfile_readback_fsm: scoreboard of expected captures, checked with immediate assertions.
module tb_regfile_readback_fsm;

    localparam logic [15:0] PI = 16'h00F0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, hold, start2;

    logic [15:0] bus_in, regEnable, inst, data_out, checksum;
    logic [3:0]  ctrlA, ctrlB, sel_idx;
    logic        valid, busy, done;
    logic [6:0]  out0, out1, out2, out3;

    logic [15:0] bus2, regEnable2, inst2, data_out2, checksum2;
    logic [3:0]  ctrlA2, ctrlB2, sel_idx2;
    logic        valid2, busy2, done2;
    logic [6:0]  out0_2, out1_2, out2_2, out3_2;

    // Register file model: register i holds 16'h1000 + i.
    assign bus_in = 16'h1000 + {12'h000, ctrlA};
    assign bus2   = 16'h1000 + {12'h000, ctrlA2};

    regfile_readback_fsm #(.NUM_REGS(16), .DWELL_CYCLES(4), .SETTLE_CYCLES(1), .PASS_INST(PI)) u1 (
        .clk(clk), .reset(reset), .start(start), .hold(hold), .bus_in(bus_in),
        .regEnable(regEnable), .ctrlA(ctrlA), .ctrlB(ctrlB), .inst(inst),
        .data_out(data_out), .sel_idx(sel_idx), .valid(valid), .busy(busy), .done(done),
        .checksum(checksum), .out0(out0), .out1(out1), .out2(out2), .out3(out3));

    regfile_readback_fsm #(.NUM_REGS(2), .DWELL_CYCLES(0), .SETTLE_CYCLES(1), .PASS_INST(PI)) u2 (
        .clk(clk), .reset(reset), .start(start2), .hold(1'b0), .bus_in(bus2),
        .regEnable(regEnable2), .ctrlA(ctrlA2), .ctrlB(ctrlB2), .inst(inst2),
        .data_out(data_out2), .sel_idx(sel_idx2), .valid(valid2), .busy(busy2), .done(done2),
        .checksum(checksum2), .out0(out0_2), .out1(out1_2), .out2(out2_2), .out3(out3_2));

    typedef struct {
        logic [15:0] d;
        logic [3:0]  i;
        int          gap;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lastv1 = 0;
    int lastv2 = 0;
    logic [15:0] ld1, ld2;

    function automatic logic [6:0] seg(input logic [3:0] h);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[h];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            chk("u1_regEnable", regEnable, 32'h0);
            if (valid) begin
                chk("u1_pending", 32'(q1.size() != 0), 32'h1);
                if (q1.size() != 0) begin
                    e1 = q1.pop_front();
                    chk("u1_data", data_out, e1.d);
                    chk("u1_sel_idx", sel_idx, e1.i);
                    chk("u1_ctrlB", ctrlB, ctrlA);
                    chk("u1_gap", cyc - lastv1, e1.gap);
                end
                lastv1 = cyc;
            end
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            chk("u2_regEnable", regEnable2, 32'h0);
            if (valid2) begin
                chk("u2_pending", 32'(q2.size() != 0), 32'h1);
                if (q2.size() != 0) begin
                    e2 = q2.pop_front();
                    chk("u2_data", data_out2, e2.d);
                    chk("u2_sel_idx", sel_idx2, e2.i);
                    chk("u2_gap", cyc - lastv2, e2.gap);
                end
                lastv2 = cyc;
            end
        end
    end

    task automatic push_scan(input int hold_idx, input int extra);
        for (int i = 0; i < 16; i++)
            q1.push_back('{16'h1000 + 16'(i), 4'(i), (i == 0) ? 3 : ((i == hold_idx) ? 7 + extra : 7)});
`ifdef REGFILE_READBACK_CHECKSUM_EN
        q1.push_back('{16'h0078, 4'hF, 5});
`endif
    endtask

    task automatic kick1();
        @(negedge clk);
        start = 1'b1;
        lastv1 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done1(input string tag);
        int n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, done, 32'h1);
    endtask

    task automatic wait_idx1(input logic [3:0] k);
        int n = 0;
        while (!(valid && sel_idx == k) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait_valid_idx", {valid, sel_idx}, {1'b1, k});
    endtask

    task automatic chk_cleared();
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_sel_idx", sel_idx, 32'h0);
        chk("rst_valid", valid, 32'h0);
        chk("rst_busy", busy, 32'h0);
        chk("rst_done", done, 32'h0);
        chk("rst_ctrlA", ctrlA, 32'h0);
        chk("rst_ctrlB", ctrlB, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_checksum", checksum, 32'h0);
        chk("rst_digits", {out3, out2, out1, out0}, {4{seg(4'h0)}});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef REGFILE_READBACK_CHECKSUM_EN
        ld1 = 16'h0078;
        ld2 = 16'h2001;
`else
        ld1 = 16'h100F;
        ld2 = 16'h1001;
`endif
        reset = 1'b0; start = 1'b0; hold = 1'b0; start2 = 1'b0;
        repeat (3) @(negedge clk);
        chk_cleared();
        reset = 1'b1;
        @(negedge clk);

        // Plain scan: 16 captures 7 cycles apart.
        push_scan(-1, 0);
        kick1();
        chk("scan_busy", busy, 32'h1);
        chk("scan_inst", inst, PI);
        chk("scan_done_low", done, 32'h0);
        wait_done1("scan1_done");
        chk("scan1_drained", q1.size(), 32'h0);
        chk("done_busy", busy, 32'h0);
        chk("done_inst", inst, 32'h0);
        chk("done_data", data_out, ld1);
        chk("done_sel_idx", sel_idx, 32'hF);
        chk("done_ctrlA", ctrlA, 32'hF);
        chk("done_digits", {out3, out2, out1, out0},
            {seg(ld1[15:12]), seg(ld1[11:8]), seg(ld1[7:4]), seg(ld1[3:0])});
`ifdef REGFILE_READBACK_CHECKSUM_EN
        chk("done_checksum", checksum, 32'h0078);
`else
        chk("done_checksum", checksum, 32'h0);
`endif

        // Hold during register 3's dwell, start pulse at register 7 ignored.
        push_scan(4, 10);
        kick1();
        wait_idx1(4'd3);
        hold = 1'b1;
        repeat (10) @(negedge clk);
        hold = 1'b0;
        wait_idx1(4'd7);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_ignored_busy", busy, 32'h1);
        wait_done1("scan2_done");
        chk("scan2_drained", q1.size(), 32'h0);

        // Start high in DONE restarts on the next edge.
        push_scan(-1, 0);
        start = 1'b1;
        lastv1 = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("restart_busy", busy, 32'h1);
        chk("restart_done", done, 32'h0);
        chk("restart_ctrlA", ctrlA, 32'h0);
        chk("restart_inst", inst, PI);

        // Reset in the middle of register 5's dwell.
        wait_idx1(4'd5);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_cleared();
        q1.delete();
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_rst_busy", busy, 32'h0);
        chk("post_rst_done", done, 32'h0);
        chk("post_rst_data", data_out, 32'h0);

        // Two registers, dwell 0 treated as 1.
        q2.push_back('{16'h1000, 4'h0, 3});
        q2.push_back('{16'h1001, 4'h1, 4});
`ifdef REGFILE_READBACK_CHECKSUM_EN
        q2.push_back('{16'h2001, 4'hF, 2});
`endif
        @(negedge clk);
        start2 = 1'b1;
        lastv2 = cyc;
        @(negedge clk);
        start2 = 1'b0;
        for (int n = 0; n < 50 && !done2; n++) @(negedge clk);
        chk("u2_done", done2, 32'h1);
        chk("u2_drained", q2.size(), 32'h0);
        chk("u2_data_final", data_out2, ld2);
        chk("u2_digits", {out3_2, out2_2, out1_2, out0_2},
            {seg(ld2[15:12]), seg(ld2[11:8]), seg(ld2[7:4]), seg(ld2[3:0])});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_readback_fsm.md
Name: regfile_readback_fsm

Overview:
- Read-only scanner for the register-file/ALU datapath; the reader counterpart to the sequencer FSMs that write the registers.
- On start, walks register indices 0..NUM_REGS-1, drives the datapath's A/B read selects with a pass-through instruction, and captures the datapath bus for each register.
- Holds each captured value on four hex 7-segment digits for a dwell period, so the board shows the result of a prior write sequence register by register.
- Never asserts any register write enable.

Parameters:
- NUM_REGS, 16, registers scanned (2..16).
- DWELL_CYCLES, 25000000, display hold per register in clk cycles; value 0 is treated as 1.
- SETTLE_CYCLES, 1, cycles between a select change and capture (>=1).
- PASS_INST, 16'h0000, instruction word that makes the datapath output operand A on the bus.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset.
- start  in  1  level; sampled in IDLE/DONE to begin a scan.
- hold  in  1  freezes the dwell counter while 1.
- bus_in  in  16  datapath bus output (C).
- regEnable  out  16  register write enables; constant 0.
- ctrlA  out  4  operand A read select.
- ctrlB  out  4  operand B read select; always equal to ctrlA.
- inst  out  16  datapath instruction.
- data_out  out  16  last captured value.
- sel_idx  out  4  index of the register in data_out.
- valid  out  1  one-cycle pulse when data_out updates.
- busy  out  1  1 outside IDLE/DONE.
- done  out  1  1 in DONE.
- checksum  out  16  see Optional Feature.
- out0,out1,out2,out3  out  7  hex 7-seg of data_out[3:0]..[15:12] (existing hexTo7Seg).

Behaviour:
- Reset (reset=0, async) clears all outputs:
  - state=IDLE; ctrlA=ctrlB=0; inst=0; data_out=0; sel_idx=0; valid=0; busy=0; done=0; checksum=0.
  - Digits show "0000".
- All outputs are registered; regEnable is tied to 16'h0000 in every state.
- States IDLE, SELECT, CAPTURE, DWELL, NEXT, SUM (feature only), DONE:
  - IDLE:
    - start=1 → SELECT with idx=0, ctrlA=ctrlB=0, inst=PASS_INST, busy=1.
  - SELECT:
    - Counts SETTLE_CYCLES cycles, then → CAPTURE.
    - hold is ignored here.
  - CAPTURE (1 cycle):
    - data_out<=bus_in; sel_idx<=idx; valid=1 for exactly this cycle.
    - → DWELL with the counter cleared.
  - DWELL:
    - Counter increments each cycle with hold=0 and holds its value while hold=1.
    - At count DWELL_CYCLES-1 with hold=0 → NEXT.
  - NEXT (1 cycle):
    - If idx==NUM_REGS-1 → SUM (feature) or DONE.
    - Else idx+1, ctrlA/ctrlB updated, → SELECT.
  - DONE:
    - done=1, busy=0; data_out and digits keep the last value; inst=0.
    - start=1 → SELECT with idx=0 (rescan); done clears on that transition.
- Per-register period = SETTLE_CYCLES + 1 + DWELL_CYCLES + 1 cycles, excluding hold stalls.
- start while busy is ignored. Holding start high in DONE restarts immediately, giving continuous scanning.
- idx never exceeds NUM_REGS-1; no wrap inside a scan.
- Reset asserted mid-scan aborts immediately to IDLE with the reset values above; there is no partial-scan resume.
- Illegal state encoding → IDLE on the next edge.

Optional Feature:
- Macro: REGFILE_READBACK_CHECKSUM_EN.
- With the macro defined:
  - checksum is cleared on scan start and accumulates (checksum + bus_in) mod 2^16 in each CAPTURE.
  - After the last NEXT, SUM state: data_out<=checksum, sel_idx<=4'hF, one valid pulse, then one full dwell (hold-aware) → DONE.
- Without the macro: checksum is tied 0, there is no SUM state, and NEXT on the last register goes directly to DONE.

Test Plan:
- Reset mid-DWELL at register 5 → all outputs zero within the same cycle as reset falling; IDLE after release; no valid pulse.
- Bench regfile model with bus_in = 16'h1000+ctrlA, DWELL_CYCLES=4, SETTLE_CYCLES=1, start pulse → 16 valid pulses 7 cycles apart, data_out 16'h1000..16'h100F matching sel_idx 0..15, then done=1; regEnable==0 on every cycle.
- Same setup, hold=1 for 10 cycles during register 3's DWELL → register 4's valid arrives exactly 10 cycles late; the SELECT/CAPTURE timing of the other registers is unchanged.
- start pulsed mid-scan at register 7 → ignored: sequence continues 8..15 without restarting; start held high in DONE → new scan begins at idx 0 the next cycle.
- CHECKSUM_EN defined, regs=16'h1000+i → after register 15, a valid pulse with data_out=16'h0078 (sum mod 2^16) and sel_idx=4'hF, one dwell, then done.
- NUM_REGS=2, DWELL_CYCLES=0 → registers 0 and 1 captured with a 1-cycle dwell, done after register 1; out3..out0 decode 16'h1001 to digits "1001".
